// File: rtl/gsplat_vtiming.sv
// Runtime-reprogrammable video timing generator: pixel enable, H/V counters, syncs, blanks,
// DE, frame-start and frame counter. Offered modes are staged and switch in only at frame end.
module gsplat_vtiming #(
    parameter int CE_DIV = 2,
    parameter int CNT_W  = 12,
    parameter int FCNT_W = 16,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [4*CNT_W-1:0]   cfg_h,
    input  logic [4*CNT_W-1:0]   cfg_v,
    input  logic [1:0]           cfg_pol,
    output logic                 cfg_err,
    output logic                 ce_pix,
    output logic [CNT_W-1:0]     hc,
    output logic [CNT_W-1:0]     vc,
    output logic                 hs,
    output logic                 vs,
    output logic                 hblank,
    output logic                 vblank,
    output logic                 de,
    output logic                 frame_start,
    output logic [FCNT_W-1:0]    frame_cnt,
    output logic                 dbg_cfg_state
);
    // cfg handshake: a mode transfers on the clk edge where cfg_valid && cfg_ready are both
    // high; cfg_valid may be held while cfg_ready is low and nothing is consumed then.

    localparam int DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int SUM_W = CNT_W + 2;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } cfg_state_t;

    cfg_state_t          r_state;
    cfg_state_t          w_state_nxt;

    logic [DIV_W-1:0]    r_div;
    logic                r_ce;
    logic [CNT_W-1:0]    r_hc;
    logic [CNT_W-1:0]    r_vc;
    logic [FCNT_W-1:0]   r_fcnt;
    logic                r_err;

    logic [CNT_W-1:0]    r_h_act, r_h_fp, r_h_sync, r_h_bp;
    logic [CNT_W-1:0]    r_v_act, r_v_fp, r_v_sync, r_v_bp;
    logic                r_hs_pol, r_vs_pol;

    logic [4*CNT_W-1:0]  r_sh_h;
    logic [4*CNT_W-1:0]  r_sh_v;
    logic [1:0]          r_sh_pol;

    logic                w_mode_ok;
    logic                w_take;
    logic                w_reject;
    logic                w_apply;
    logic                w_frame_end;
    logic                w_h_end;
    logic                w_v_end;
    logic [SUM_W-1:0]    w_hs_beg, w_hs_end, w_h_tot;
    logic [SUM_W-1:0]    w_vs_beg, w_vs_end, w_v_tot;
    logic [CNT_W-1:0]    w_h_last, w_v_last;
    logic                w_hs_on, w_vs_on;

    // Sums are taken CNT_W+2 wide so an oversized total is caught rather than wrapped.
    function automatic logic mode_ok(input logic [4*CNT_W-1:0] m);
        logic [SUM_W-1:0] sum;
        logic             nz;
        sum = '0;
        nz  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sum = sum + SUM_W'(m[i*CNT_W +: CNT_W]);
            nz  = nz & (|m[i*CNT_W +: CNT_W]);
        end
        return nz && (sum[SUM_W-1:CNT_W] == 2'b00);
    endfunction

    assign w_mode_ok = mode_ok(cfg_h) & mode_ok(cfg_v);

    assign w_hs_beg = SUM_W'(r_h_act) + SUM_W'(r_h_fp);
    assign w_hs_end = w_hs_beg + SUM_W'(r_h_sync);
    assign w_h_tot  = w_hs_end + SUM_W'(r_h_bp);
    assign w_vs_beg = SUM_W'(r_v_act) + SUM_W'(r_v_fp);
    assign w_vs_end = w_vs_beg + SUM_W'(r_v_sync);
    assign w_v_tot  = w_vs_end + SUM_W'(r_v_bp);
    assign w_h_last = CNT_W'(w_h_tot - SUM_W'(1));
    assign w_v_last = CNT_W'(w_v_tot - SUM_W'(1));

    assign w_h_end     = (r_hc == w_h_last);
    assign w_v_end     = (r_vc == w_v_last);
    assign w_frame_end = r_ce & w_h_end & w_v_end;

    // Config FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Config FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (cfg_valid && w_mode_ok) w_state_nxt = S_PENDING;
            S_PENDING: if (w_frame_end)            w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Config FSM: outputs
    always_comb begin
        cfg_ready = 1'b0;
        w_take    = 1'b0;
        w_reject  = 1'b0;
        w_apply   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                w_take    = cfg_valid & w_mode_ok;
                w_reject  = cfg_valid & ~w_mode_ok;
            end
            S_PENDING: w_apply = w_frame_end;
            default: ;
        endcase
    end

    assign dbg_cfg_state = (r_state == S_PENDING);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div <= '0;
            r_ce  <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_ce  <= 1'b1;
        end else begin
            r_div <= r_div + DIV_W'(1);
            r_ce  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hc   <= '0;
            r_vc   <= '0;
            r_fcnt <= '0;
        end else if (r_ce) begin
            if (w_h_end) begin
                r_hc <= '0;
                r_vc <= w_v_end ? '0 : r_vc + CNT_W'(1);
            end else begin
                r_hc <= r_hc + CNT_W'(1);
            end
            if (w_h_end && w_v_end) begin
                r_fcnt <= r_fcnt + FCNT_W'(1);
            end
        end
    end

    // Active mode only changes at frame end, so no frame mixes two timings.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            {r_h_act, r_h_fp, r_h_sync, r_h_bp} <= {CNT_W'(H_ACT), CNT_W'(H_FP),
                                                    CNT_W'(H_SYNC), CNT_W'(H_BP)};
            {r_v_act, r_v_fp, r_v_sync, r_v_bp} <= {CNT_W'(V_ACT), CNT_W'(V_FP),
                                                    CNT_W'(V_SYNC), CNT_W'(V_BP)};
            r_hs_pol <= HS_POL;
            r_vs_pol <= VS_POL;
        end else if (w_apply) begin
            {r_h_act, r_h_fp, r_h_sync, r_h_bp} <= r_sh_h;
            {r_v_act, r_v_fp, r_v_sync, r_v_bp} <= r_sh_v;
            {r_hs_pol, r_vs_pol}                <= r_sh_pol;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sh_h   <= '0;
            r_sh_v   <= '0;
            r_sh_pol <= 2'b00;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_take) begin
                r_sh_h   <= cfg_h;
                r_sh_v   <= cfg_v;
                r_sh_pol <= cfg_pol;
            end
        end
    end

    assign w_hs_on = (SUM_W'(r_hc) >= w_hs_beg) && (SUM_W'(r_hc) < w_hs_end);
    assign w_vs_on = (SUM_W'(r_vc) >= w_vs_beg) && (SUM_W'(r_vc) < w_vs_end);

    assign ce_pix      = r_ce;
    assign hc          = r_hc;
    assign vc          = r_vc;
    assign frame_cnt   = r_fcnt;
    assign cfg_err     = r_err;
    assign hblank      = (r_hc >= r_h_act);
    assign vblank      = (r_vc >= r_v_act);
    assign de          = ~hblank & ~vblank;
    assign hs          = r_hs_pol ? w_hs_on : ~w_hs_on;
    assign vs          = r_vs_pol ? w_vs_on : ~w_vs_on;
    assign frame_start = r_ce & (r_hc == '0) & (r_vc == '0);

endmodule

// File: tb/tb_gsplat_vtiming.sv
// Bench for gsplat_vtiming: a pixel-index reference model predicts every output each cycle
// into a queue that a negedge monitor drains; a second instance covers CE_DIV=1 / FCNT_W=4.
module tb_gsplat_vtiming;
    localparam int CW  = 12;
    localparam int FW  = 16;
    localparam int EW  = 10 + 2*CW + FW;
    localparam int DIV = 2;
    localparam int DH[4] = '{20, 2, 3, 3};
    localparam int DV[4] = '{10, 1, 2, 2};
    localparam int FRAME2 = 28 * 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n, cfg_valid, cfg_ready, cfg_err, ce_pix;
    logic [4*CW-1:0] cfg_h, cfg_v;
    logic [1:0]      cfg_pol;
    logic [CW-1:0]   hc, vc;
    logic            hs, vs, hblank, vblank, de, frame_start, dbg_state;
    logic [FW-1:0]   frame_cnt;

    logic            rst2_n, ready2, err2, ce2, hs2, vs2, hb2, vb2, de2, fs2, dbg2;
    logic [CW-1:0]   hc2, vc2;
    logic [3:0]      fc2;

    gsplat_vtiming #(
        .CE_DIV(DIV), .CNT_W(CW), .FCNT_W(FW),
        .H_ACT(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pol(cfg_pol), .cfg_err(cfg_err),
        .ce_pix(ce_pix), .hc(hc), .vc(vc), .hs(hs), .vs(vs), .hblank(hblank),
        .vblank(vblank), .de(de), .frame_start(frame_start), .frame_cnt(frame_cnt),
        .dbg_cfg_state(dbg_state)
    );

    gsplat_vtiming #(
        .CE_DIV(1), .CNT_W(CW), .FCNT_W(4),
        .H_ACT(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut2 (
        .clk(clk), .reset_n(rst2_n), .cfg_valid(1'b0), .cfg_ready(ready2),
        .cfg_h('0), .cfg_v('0), .cfg_pol(2'b00), .cfg_err(err2),
        .ce_pix(ce2), .hc(hc2), .vc(vc2), .hs(hs2), .vs(vs2), .hblank(hb2),
        .vblank(vb2), .de(de2), .frame_start(fs2), .frame_cnt(fc2),
        .dbg_cfg_state(dbg2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];
    bit dut2_done = 1'b0;

    // ---------------- reference model ----------------
    int   m_t, m_p;
    bit   m_ce, m_pend, m_err;
    int   cur_h[4], cur_v[4], sh_h[4], sh_v[4];
    bit [1:0] cur_pol, sh_pol;
    logic [FW-1:0] m_fcnt;

    function automatic int cur_ht();
        return cur_h[0] + cur_h[1] + cur_h[2] + cur_h[3];
    endfunction

    function automatic int cur_vt();
        return cur_v[0] + cur_v[1] + cur_v[2] + cur_v[3];
    endfunction

    function automatic int fld(input logic [4*CW-1:0] bus, input int i);
        return int'(bus[(4-i)*CW-1 -: CW]);
    endfunction

    function automatic bit bus_ok(input logic [4*CW-1:0] bus);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            if (fld(bus, i) == 0) return 1'b0;
            s += fld(bus, i);
        end
        return s < (1 << CW);
    endfunction

    function automatic logic [EW-1:0] expected();
        int x, y, h0, h1, v0, v1;
        bit hb, vb, hon, von, ho, vo;
        x   = m_p % cur_ht();
        y   = m_p / cur_ht();
        h0  = cur_h[0] + cur_h[1];
        h1  = h0 + cur_h[2];
        v0  = cur_v[0] + cur_v[1];
        v1  = v0 + cur_v[2];
        hb  = x >= cur_h[0];
        vb  = y >= cur_v[0];
        hon = (x >= h0) && (x < h1);
        von = (y >= v0) && (y < v1);
        ho  = cur_pol[1] ? hon : !hon;
        vo  = cur_pol[0] ? von : !von;
        return {m_ce, !m_pend, m_err, CW'(x), CW'(y), ho, vo, hb, vb,
                !hb && !vb, m_ce && (m_p == 0), m_fcnt};
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_t = 0; m_p = 0; m_ce = 0; m_pend = 0; m_err = 0; m_fcnt = '0;
            cur_h = DH; cur_v = DV; cur_pol = 2'b00;
        end else begin
            bit fe, xfer;
            fe   = m_ce && (m_p == cur_ht() * cur_vt() - 1);
            xfer = cfg_valid && !m_pend;
            m_err = 0;
            if (fe) begin
                m_fcnt = m_fcnt + 1'b1;
                if (m_pend) begin
                    cur_h = sh_h; cur_v = sh_v; cur_pol = sh_pol; m_pend = 0;
                end
            end
            if (xfer) begin
                if (bus_ok(cfg_h) && bus_ok(cfg_v)) begin
                    for (int i = 0; i < 4; i++) begin
                        sh_h[i] = fld(cfg_h, i);
                        sh_v[i] = fld(cfg_v, i);
                    end
                    sh_pol = cfg_pol;
                    m_pend = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (m_ce) m_p = fe ? 0 : m_p + 1;
            m_t++;
            m_ce = (m_t % DIV) == 0;
        end
        exp_q.push_back(expected());
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e, a;
            e = exp_q.pop_front();
            a = {ce_pix, cfg_ready, cfg_err, hc, vc, hs, vs, hblank, vblank, de,
                 frame_start, frame_cnt};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL outputs @%0t got=%h exp=%h", $time, a, e);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int h0, h1, h2, h3, v0, v1, v2, v3, input logic [1:0] pol);
        cfg_h   = {CW'(h0), CW'(h1), CW'(h2), CW'(h3)};
        cfg_v   = {CW'(v0), CW'(v1), CW'(v2), CW'(v3)};
        cfg_pol = pol;
    endtask

    task automatic send_cfg(input int h0, h1, h2, h3, v0, v1, v2, v3, input logic [1:0] pol);
        bit got = 0;
        set_mode(h0, h1, h2, h3, v0, v1, v2, v3, pol);
        cfg_valid = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (cfg_ready) begin got = 1; break; end
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        n_checks++;
        if (got) n_pass++;
        else $display("FAIL cfg_handshake got=no_ready exp=ready");
    endtask

    task automatic offer_at_frame_end(input int h0, h1, h2, h3, v0, v1, v2, v3,
                                      input logic [1:0] pol);
        bit hit = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (m_ce && !m_pend && m_p == cur_ht() * cur_vt() - 1) begin hit = 1; break; end
        end
        set_mode(h0, h1, h2, h3, v0, v1, v2, v3, pol);
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        n_checks++;
        if (hit) n_pass++;
        else $display("FAIL frame_end_wait got=timeout exp=frame_end");
    endtask

    task automatic reset_while_pending(input int at_hc);
        bit hit = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (m_pend && m_ce && (m_p % cur_ht()) == at_hc) begin hit = 1; break; end
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        n_checks++;
        if (hit) n_pass++;
        else $display("FAIL pending_wait got=timeout exp=pending_at_hc");
    endtask

    // ---------------- CE_DIV=1, FCNT_W=4 instance ----------------
    initial begin
        int ce_bad = 0, fs_cnt = 0;
        bit wrapped = 0;
        logic [3:0] prev = '0;
        rst2_n = 1'b0;
        tick(3);
        rst2_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 17 * FRAME2; i++) begin
            @(negedge clk);
            if (ce2 !== 1'b1) ce_bad++;
            if (fs2 === 1'b1) fs_cnt++;
            if (prev == 4'd15 && fc2 == 4'd0) wrapped = 1;
            prev = fc2;
        end
        n_checks++;
        if (ce_bad == 0) n_pass++;
        else $display("FAIL ce1_const got=%0d_low_cycles exp=0", ce_bad);
        n_checks++;
        if (fs_cnt == 17) n_pass++;
        else $display("FAIL frame_start_pulses got=%0d exp=17", fs_cnt);
        n_checks++;
        if (wrapped) n_pass++;
        else $display("FAIL fcnt_wrap got=no_wrap exp=15_to_0");
        n_checks++;
        if (fc2 == 4'd0) n_pass++;
        else $display("FAIL fcnt_after_16 got=%0d exp=0", fc2);
        dut2_done = 1'b1;
    end

    // ---------------- main sequence ----------------
    initial begin
        int guard = 0;
        reset_n = 1'b0; cfg_valid = 1'b0;
        set_mode(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        tick(3);
        reset_n = 1'b1;
        tick(2 * 840 + 50);

        send_cfg(16, 2, 4, 2, 8, 1, 1, 2, 2'b11);
        tick(2000);

        send_cfg(20, 2, 0, 3, 10, 1, 2, 2, 2'b00);
        tick(5);
        send_cfg(4000, 40, 40, 16, 10, 1, 2, 2, 2'b00);
        tick(5);
        send_cfg(4095, 1, 1, 1, 10, 1, 2, 2, 2'b00);
        tick(300);

        offer_at_frame_end(12, 2, 2, 2, 6, 1, 1, 1, 2'b10);
        tick(3 * 2 * 18 * 9 + 100);

        send_cfg(18, 2, 3, 3, 9, 1, 2, 2, 2'b01);
        reset_while_pending(10);
        tick(1000);

        for (int k = 0; k < 14; k++) begin
            int ha, va;
            ha = $urandom_range(4, 16);
            va = $urandom_range(3, 10);
            if ($urandom_range(0, 7) == 0) ha = 4095;
            send_cfg(ha, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                     va, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     2'($urandom_range(0, 3)));
            tick($urandom_range(0, 600));
        end
        tick(2500);

        while (!dut2_done && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        if (!dut2_done) begin
            n_checks++;
            $display("FAIL dut2_done got=timeout exp=done");
        end
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
